// File: rtl/ifu_axi_fetch_if.sv
// Fetch-side and AXI4-Lite signals of ifu_axi_fetch.
// The master modport is the fetch block's view; slave is the environment's view.
interface ifu_axi_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              req_ready;
  logic              flush;
  logic              rvalid_out;
  logic [DATA_W-1:0] rdata_out;
  logic              rerr_out;
  logic              rready_in;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                bready;
  logic                awready;
  logic                wready;
  logic                bvalid;
  logic [1:0]          bresp;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    input  req, addr, flush, rready_in,
    input  awready, wready, bvalid, bresp,
    input  arready, rdata, rresp, rvalid,
    output req_ready, rvalid_out, rdata_out, rerr_out,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready
  );

  modport slave (
    output req, addr, flush, rready_in,
    output awready, wready, bvalid, bresp,
    output arready, rdata, rresp, rvalid,
    input  req_ready, rvalid_out, rdata_out, rerr_out,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready
  );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch master: core fetch requests become AXI4-Lite reads, with
// multiple outstanding reads, an in-order response FIFO and flush-based discard.
module ifu_axi_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          rst_n,
  ifu_axi_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_e;

  ar_state_e         ar_state_q, ar_state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0][DATA_W:0] mem_q;  // {err, data}
  logic              alive_q;
  logic              acc, r_hs, push, pop;
  logic [CW:0]       occ;
  logic              unused_axi;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // alive_q keeps every output low while in reset and for the first edge after it
  assign occ            = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign bus.req_ready  = alive_q && (ar_state_q == AR_IDLE) && !bus.flush &&
                          (occ < (CW+1)'(DEPTH));
  assign bus.arvalid    = (ar_state_q == AR_BUSY);
  assign bus.araddr     = araddr_q;
  assign bus.rready     = alive_q && (fifo_cnt_q < CW'(DEPTH));
  assign bus.rvalid_out = (fifo_cnt_q != '0);
  assign {bus.rerr_out, bus.rdata_out} = bus.rvalid_out ? mem_q[rd_ptr_q] : '0;

  assign acc  = bus.req && bus.req_ready;
  assign r_hs = bus.rvalid && bus.rready;
  assign push = r_hs && !bus.flush && (drop_cnt_q == '0);
  assign pop  = bus.rvalid_out && bus.rready_in && !bus.flush;

  assign bus.awaddr  = '0;
  assign bus.awvalid = 1'b0;
  assign bus.wdata   = '0;
  assign bus.wstrb   = '0;
  assign bus.wvalid  = 1'b0;
  assign bus.bready  = 1'b0;
  assign unused_axi  = ^{bus.awready, bus.wready, bus.bvalid, bus.bresp};

  always_comb begin
    ar_state_d = ar_state_q;
    araddr_d   = araddr_q;
    case (ar_state_q)
      AR_IDLE: if (acc) begin
        ar_state_d = AR_BUSY;
        araddr_d   = bus.addr;
      end
      // AR is never withdrawn once raised, flush or not
      AR_BUSY: if (bus.arready) ar_state_d = AR_IDLE;
      default: ar_state_d = AR_IDLE;
    endcase

    inflight_d = inflight_q + CW'(acc) - CW'(r_hs);

    drop_cnt_d = drop_cnt_q;
    if (bus.flush)                     drop_cnt_d = inflight_d;
    else if (r_hs && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);

    fifo_cnt_d = fifo_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.flush) begin
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
      else if (pop && !push) fifo_cnt_d = fifo_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state_q <= AR_IDLE;
      araddr_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      alive_q    <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      araddr_q   <= araddr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      alive_q    <= 1'b1;
    end
  end

  // Storage needs no reset: the read port is gated by rvalid_out
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.rresp != 2'b00, bus.rdata};
  end

`ifdef SIMULATION
  logic [63:0] perf_fetch_cnt, perf_ar_stall_cycles, perf_drop_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt       <= '0;
      perf_ar_stall_cycles <= '0;
      perf_drop_cnt        <= '0;
    end else begin
      if (push)                         perf_fetch_cnt       <= perf_fetch_cnt + 64'd1;
      if (bus.arvalid && !bus.arready)  perf_ar_stall_cycles <= perf_ar_stall_cycles + 64'd1;
      if (r_hs && !push)                perf_drop_cnt        <= perf_drop_cnt + 64'd1;
    end
  end
`endif
endmodule

// File: doc/ifu_axi_fetch.md
# ifu_axi_fetch

Parametrised instruction-fetch master that turns core fetch requests into AXI4-Lite read transactions. It supports multiple outstanding reads, a response FIFO with a valid/ready handshake toward the decoder, a pipeline flush that discards stale responses, and error reporting. It sits between the IFU front end and the SoC AXI4-Lite crossbar, in place of the single-cycle SRAM fetch path. The write channels are tied off because the block is read-only.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, instruction/data width
- DEPTH, 2, maximum reads in flight plus buffered responses; power of two, ≥1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  fetch request; accepted when req && req_ready
- addr  in  ADDR_W  fetch address, sampled on acceptance
- req_ready  out  1  block can accept a request this cycle
- flush  in  1  discard all outstanding and buffered fetches
- rvalid_out  out  1  head-of-FIFO instruction valid
- rdata_out  out  DATA_W  instruction word
- rerr_out  out  1  rresp was non-OKAY for this word
- rready_in  in  1  consumer accepts head entry
- awaddr/awvalid/wdata/wstrb/wvalid/bready  out  —  constant 0 (ADDR_W/1/DATA_W/DATA_W/8/1/1)
- awready, wready, bvalid  in  1  ignored
- bresp  in  2  ignored
- araddr  out  ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  slave accepts AR
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  master accepts R

## Operation
- Counters:
  - inflight counts ARs issued (pending or accepted) with no R yet; width $clog2(DEPTH+1).
  - fifo_cnt counts buffered responses.
  - drop_cnt counts responses still to be discarded.
- req_ready = !arvalid && !flush && (inflight + fifo_cnt) < DEPTH. It is combinational from registers and flush. The reservation guarantees the FIFO never overflows.
- Request acceptance: araddr <= addr, arvalid <= 1, inflight increments.
- AR hold rule: arvalid stays high and araddr stays stable until arready. Clear on the handshake cycle. This is never withdrawn, including on flush (AXI rule).
- rready is 1 whenever fifo_cnt < DEPTH. With reservation it is effectively always 1 outside reset.
- On R handshake, inflight decrements. Then:
  - If drop_cnt > 0, the word is discarded and drop_cnt decrements.
  - Otherwise {rdata, rresp != 2'b00} is pushed to the FIFO.
- FIFO pop on rvalid_out && rready_in. Push and pop in the same cycle leaves fifo_cnt unchanged.
- Flush behaviour:
  - The FIFO is emptied (fifo_cnt <= 0, rvalid_out <= 0).
  - drop_cnt <= inflight_next, which already accounts for an R handshake in the same cycle; the word handshaked that cycle is discarded.
  - A pending AR is counted in inflight, so its eventual response is dropped.
  - A pop in the flush cycle is ignored.
- Responses arrive in order (AXI4-Lite, single ID); no reordering logic.
- Error words are delivered normally with rerr_out=1. The block takes no other action.
- Under `ifdef SIMULATION`: 64-bit counters perf_fetch_cnt (FIFO pushes), perf_ar_stall_cycles (arvalid && !arready), perf_drop_cnt (discarded responses).

## Timing
- Reset (rst_n=0, asynchronous): every output is 0, including req_ready; all counters and FIFO pointers are 0. The first req can be accepted in the cycle after rst_n deasserts.
- Reset mid-transaction abandons AR/R state immediately. The system resets the slave together with this block.
- Request accepted in cycle T → arvalid=1 from T+1.
- AR handshake in cycle A → earliest R handshake A+1 (slave-dependent).
- R handshake in cycle R → rvalid_out=1, rdata_out valid from R+1.
- Minimum req→rvalid_out latency: 3 cycles. Throughput with DEPTH=2 and zero-wait slave: one fetch per 2 cycles (AR serialisation).
- rdata_out and rerr_out are stable while rvalid_out && !rready_in.
- Simultaneous req and flush: the req is not accepted.
- Simultaneous flush and arready: the handshake completes and the response is dropped.

## Test plan
- Reset defaults: hold rst_n=0 with random inputs → all outputs 0; release rst_n → req_ready=1 next cycle.
- Single fetch with zero-wait slave:
  - req at T with addr=0x8000_0000 → arvalid/araddr=0x8000_0000 at T+1.
  - rdata=0x0000_0413 with rvalid at T+2 → rvalid_out=1, rdata_out=0x0000_0413, rerr_out=0 at T+3.
- Backpressure, DEPTH=2, rready_in=0:
  - Two fetches return 0x11, 0x22 → req_ready=0 and fifo_cnt=2.
  - Release rready_in → 0x11 then 0x22 in order, one per cycle.
- AR stall: arready low for 5 cycles → araddr stable, arvalid high throughout, req_ready=0; perf_ar_stall_cycles=5.
- Flush with 2 in flight, one AR pending:
  - Flush → rvalid_out=0 next cycle.
  - The next 2 R beats are discarded.
  - A new fetch to 0x8000_0100 returning 0xABCD_0001 is the only word delivered.
- Error: rresp=2'b10 with rdata=0xDEAD_BEEF → rvalid_out=1, rerr_out=1, rdata_out=0xDEAD_BEEF; the following OKAY fetch has rerr_out=0.
